heartbeat_rx: RTL



---
 rtl/heartbeat_pkg.sv | 11 +
 rtl/manchester_bit_dec.sv | 41 ++++
 rtl/heartbeat_rx.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/heartbeat_pkg.sv
// Shared types and widths for the heartbeat stream receiver.
package heartbeat_pkg;
  localparam int BYTE_W = 8;
  localparam int HIST_W = 16;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;
endpackage

// File: rtl/manchester_bit_dec.sv
// Manchester half-bit pair decoder: input synchronizer, phase tracking and pair check.
// A bad pair holds the phase so the next pair is taken one sample later (bit slip).
module manchester_bit_dec
  import heartbeat_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic bit_valid,
  output logic bit_val,
  output logic violation
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   prev;
  logic                   ph;

  assign s         = sync_q[SYNC_STAGES-1];
  assign bit_valid = ph & (prev ^ s);
  assign bit_val   = prev;
  assign violation = ph & ~(prev ^ s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev   <= 1'b0;
      ph     <= 1'b0;
    end else begin
      sync_q[0] <= sig_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev <= s;
      ph   <= violation ? 1'b1 : ~ph;
    end
  end

endmodule

// File: rtl/heartbeat_rx.sv
// Heartbeat stream receiver: byte framing, sequence check and HUNT/CONFIRM/LOCKED FSM.
// Optional build macro HEARTBEAT_RX_ERRCNT_EN adds a saturating err_count output.
module heartbeat_rx
  import heartbeat_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 3,
  parameter int MAX_MISS    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sig_in,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  output logic              locked,
  output logic              err_code,
  output logic              err_seq
`ifdef HEARTBEAT_RX_ERRCNT_EN
  ,
  output logic [15:0]       err_count
`endif
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] MISS_N = 4'(MAX_MISS);

  logic bit_valid, bit_val, violation;

  manchester_bit_dec #(.SYNC_STAGES(SYNC_STAGES)) u_dec (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .bit_valid (bit_valid),
    .bit_val   (bit_val),
    .violation (violation)
  );

  state_t              state, state_nxt;
  logic [HIST_W-2:0]   hist;
  logic [HIST_W-1:0]   hist_nxt;
  logic [2:0]          bit_cnt, bit_cnt_nxt;
  logic [3:0]          conf, conf_nxt, conf_inc;
  logic [3:0]          miss, miss_nxt, miss_inc;
  logic [BYTE_W-1:0]   bout_nxt, exp_byte;
  logic                vld_nxt, ec_nxt, es_nxt;
  logic                in_seq, byte_end;

  // The register keeps 15 bits; appending the incoming bit forms the 16-bit history.
  assign hist_nxt = {hist, bit_val};
  assign exp_byte = hist_nxt[HIST_W-1:BYTE_W] + 8'd1;
  assign in_seq   = (hist_nxt[BYTE_W-1:0] == exp_byte);
  assign byte_end = bit_valid & (bit_cnt == 3'd7);
  assign conf_inc = conf + 4'd1;
  assign miss_inc = miss + 4'd1;

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_valid ? bit_cnt + 3'd1 : bit_cnt;
    conf_nxt    = conf;
    miss_nxt    = miss;
    bout_nxt    = byte_out;
    vld_nxt     = 1'b0;
    ec_nxt      = 1'b0;
    es_nxt      = 1'b0;
    unique case (state)
      HUNT: begin
        if (bit_valid && in_seq) begin
          state_nxt   = (LOCK_N == 4'd1) ? LOCKED : CONFIRM;
          bit_cnt_nxt = '0;
          conf_nxt    = 4'd1;
          miss_nxt    = '0;
        end
      end
      CONFIRM: begin
        if (violation) begin
          state_nxt = HUNT;
          conf_nxt  = '0;
        end else if (byte_end) begin
          if (in_seq) begin
            conf_nxt = conf_inc;
            if (conf_inc == LOCK_N) state_nxt = LOCKED;
          end else begin
            state_nxt = HUNT;
            conf_nxt  = '0;
          end
        end
      end
      LOCKED: begin
        if (violation) begin
          ec_nxt    = 1'b1;
          state_nxt = HUNT;
          conf_nxt  = '0;
          miss_nxt  = '0;
        end else if (byte_end) begin
          // Out-of-sequence bytes are still reported; the next compare uses them as reference.
          vld_nxt  = 1'b1;
          bout_nxt = hist_nxt[BYTE_W-1:0];
          if (in_seq) begin
            miss_nxt = '0;
          end else begin
            es_nxt   = 1'b1;
            miss_nxt = miss_inc;
            if (miss_inc == MISS_N) begin
              state_nxt = HUNT;
              conf_nxt  = '0;
              miss_nxt  = '0;
            end
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      hist       <= '0;
      bit_cnt    <= '0;
      conf       <= '0;
      miss       <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      locked     <= 1'b0;
      err_code   <= 1'b0;
      err_seq    <= 1'b0;
    end else begin
      state      <= state_nxt;
      if (bit_valid) hist <= hist_nxt[HIST_W-2:0];
      bit_cnt    <= bit_cnt_nxt;
      conf       <= conf_nxt;
      miss       <= miss_nxt;
      byte_out   <= bout_nxt;
      byte_valid <= vld_nxt;
      locked     <= (state_nxt == LOCKED);
      err_code   <= ec_nxt;
      err_seq    <= es_nxt;
    end
  end

`ifdef HEARTBEAT_RX_ERRCNT_EN
  function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_count <= '0;
    else        err_count <= sat_add(err_count, {1'b0, ec_nxt} + {1'b0, es_nxt});
  end
`endif

endmodule
